mem_rmw_master: RTL and testbench

Memory-side initiator that drives the single-cycle `BankedMEM` word memory on behalf of the CPU load/store path. It takes byte/half/word load and store requests over a valid/ready handshake and issues word-aligned accesses to the memory. It performs read-modify-write for sub-word stores, and extracts and sign- or zero-extends sub-word loads. It returns exactly one response pulse per accepted request.

---
 rtl/mem_rmw_master_if.sv | 38 +++
 rtl/mem_rmw_master.sv | 137 +++++++++++++
 tb/tb_mem_rmw_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rmw_master_if.sv
// Request/response handshake and word-memory bus of mem_rmw_master.
// The master modport is the block's view; slave is the CPU-plus-memory side.
interface mem_rmw_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              mem_writeEn;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writeData;
  logic [31:0]       mem_readData;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_writeEn, mem_address, mem_writeData,
    input  mem_readData
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_writeEn, mem_address, mem_writeData,
    output mem_readData
  );
endinterface

// File: rtl/mem_rmw_master.sv
// Byte/half/word load-store initiator for a single-cycle word memory, with read-modify-write for sub-word stores.
// Optional macro MEM_RMW_ALIGN_CHECK_EN turns misaligned or reserved-size requests into error responses.
module mem_rmw_master #(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_rmw_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, LD, RD, WR, RESP} state_t;

  state_t            state_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [31:0]       memWdata_q;
  logic [31:0]       respRdata_q;
  logic              respErr_q;

  logic [1:0]  reqSize_d;
  logic [1:0]  reqLane_d;
  logic        reqErr_d;
  logic [31:0] shifted_d;
  logic [31:0] loadData_d;
  logic [31:0] mergeData_d;

  // Normalise the incoming request: either flag bad alignment or force it.
  always_comb begin
    reqErr_d  = 1'b0;
    reqSize_d = bus.req_size;
    reqLane_d = bus.req_addr[1:0];
`ifdef MEM_RMW_ALIGN_CHECK_EN
    case (bus.req_size)
      2'b01:   reqErr_d = bus.req_addr[0];
      2'b10:   reqErr_d = |bus.req_addr[1:0];
      2'b11:   reqErr_d = 1'b1;
      default: reqErr_d = 1'b0;
    endcase
`else
    if (bus.req_size == 2'b11) reqSize_d = 2'b10;
    case (reqSize_d)
      2'b01:   reqLane_d = {bus.req_addr[1], 1'b0};
      2'b10:   reqLane_d = 2'b00;
      default: reqLane_d = bus.req_addr[1:0];
    endcase
`endif
  end

  always_comb begin
    shifted_d = bus.mem_readData >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   loadData_d = unsigned_q ? {24'd0, shifted_d[7:0]}
                                       : {{24{shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   loadData_d = unsigned_q ? {16'd0, shifted_d[15:0]}
                                       : {{16{shifted_d[15]}}, shifted_d[15:0]};
      default: loadData_d = bus.mem_readData;
    endcase
  end

  always_comb begin
    mergeData_d = bus.mem_readData;
    if (size_q == 2'b00) begin
      mergeData_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      mergeData_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Word stores skip RD; errors skip the memory entirely and keep the old address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'd0;
      memAddr_q   <= '0;
      memWdata_q  <= 32'd0;
      respRdata_q <= 32'd0;
      respErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            size_q     <= reqSize_d;
            unsigned_q <= bus.req_unsigned;
            lane_q     <= reqLane_d;
            wdata_q    <= bus.req_wdata[15:0];
            if (reqErr_d) begin
              respErr_q   <= 1'b1;
              respRdata_q <= 32'd0;
              state_q     <= RESP;
            end else begin
              memAddr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (!bus.req_write) begin
                state_q <= LD;
              end else if (reqSize_d == 2'b10) begin
                memWdata_q <= bus.req_wdata;
                state_q    <= WR;
              end else begin
                state_q <= RD;
              end
            end
          end
        end
        LD: begin
          respRdata_q <= loadData_d;
          respErr_q   <= 1'b0;
          state_q     <= RESP;
        end
        RD: begin
          memWdata_q <= mergeData_d;
          state_q    <= WR;
        end
        WR: begin
          respRdata_q <= 32'd0;
          respErr_q   <= 1'b0;
          state_q     <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.resp_valid    = (state_q == RESP);
  assign bus.resp_rdata    = respRdata_q;
  assign bus.resp_err      = respErr_q;
  assign bus.mem_writeEn   = (state_q == WR);
  assign bus.mem_address   = memAddr_q;
  assign bus.mem_writeData = memWdata_q;

endmodule

// File: tb/tb_mem_rmw_master.sv
// Self-checking bench for mem_rmw_master: directed vector table, hand-written
// back-to-back and reset-abort sequences, then random traffic against a byte-level model.
module tb_mem_rmw_master;
  localparam int ADDR_W = 32;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          memIdx;
    logic [31:0] expWord;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_rmw_master_if #(.ADDR_W(ADDR_W)) bus ();
  mem_rmw_master #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] memWords [0:15];
  logic [7:0]  refBytes [0:63];
  logic        pokeEn;
  logic [3:0]  pokeIdx;
  logic [31:0] pokeVal;

  int vectors = 0;
  int miscompares = 0;

  // Memory model: combinational read, write at the closing edge of a WR cycle.
  assign bus.mem_readData = memWords[bus.mem_address[5:2]];
  always @(posedge clk) begin
    if (pokeEn) memWords[pokeIdx] <= pokeVal;
    else if (bus.mem_writeEn) memWords[bus.mem_address[5:2]] <= bus.mem_writeData;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    pokeEn  = 1'b1;
    pokeIdx = idx[3:0];
    pokeVal = val;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  function automatic logic [31:0] refWord(input int w);
    return {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]};
  endfunction

  // Reference: operate on a byte array using the access rules directly.
  task automatic refModel(input logic write, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] expRdata, output logic expErr, output int expLat);
    int n;
    int base;
    longint v;
    expErr = 1'b0;
`ifdef MEM_RMW_ALIGN_CHECK_EN
    if (size == 2'd3 || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0))
      expErr = 1'b1;
`endif
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = int'(addr) - (int'(addr) % n);
    expRdata = 32'd0;
    if (expErr) begin
      expLat = 1;
    end else if (write) begin
      for (int i = 0; i < n; i++) refBytes[base+i] = wdata[8*i +: 8];
      expLat = (n == 4) ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(refBytes[base+i]) << (8*i));
      if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
      expRdata = v[31:0];
      expLat = 2;
    end
  endtask

  // Issue one request from IDLE and observe it until one cycle after its response.
  task automatic applyStimulus(input logic write, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output int weCnt, output logic protoOk);
    @(negedge clk);
    bus.req_write    = write;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; weCnt = 0; protoOk = 1'b1; rdata = 32'hx; err = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      if (bus.mem_writeEn === 1'b1) weCnt++;
      if (bus.mem_address[1:0] !== 2'b00) protoOk = 1'b0;
      if (bus.req_ready !== 1'b0) protoOk = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        lat = c;
        rdata = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) protoOk = 1'b0;
      if (bus.resp_rdata !== rdata || bus.resp_err !== err) protoOk = 1'b0;
    end
  endtask

  task automatic resetDuringStore(input int abortCycle);
    logic [31:0] oldWord;
    logic seen;
    oldWord = memWords[0];
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd1; bus.req_wdata = 32'h00000055; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c < abortCycle; c++) begin
      @(posedge clk); #1;
    end
    if (abortCycle == 2) checkOutput("weInWrBeforeAbort", bus.mem_writeEn, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abortWriteEn", bus.mem_writeEn, 1'b0);
    checkOutput("abortReadyInReset", bus.req_ready, 1'b1);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0 || bus.mem_writeEn !== 1'b0) seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0 || bus.mem_writeEn !== 1'b0) seen = 1'b1;
    end
    checkOutput("abortNoActivity", seen, 1'b0);
    checkOutput("abortMemUnchanged", memWords[0], oldWord);
    checkOutput("abortReadyAfter", bus.req_ready, 1'b1);
  endtask

  vec_t vecs [15];

  initial begin
    logic [31:0] rdata, expRdata, val;
    logic err, expErr, protoOk;
    int lat, expLat, weCnt;
    int r1Cycle, r2Cycle;
    logic [31:0] r1Data, r2Data;
    logic w, u;
    logic [1:0] sz;
    logic [31:0] a;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'd3,  32'd0,        32'hFFFFFFDE, 1'b0, 2, -1, 32'd0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'd3,  32'd0,        32'h000000DE, 1'b0, 2, -1, 32'd0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'd1,  32'h000000AA, 32'd0,        1'b0, 3,  0, 32'hDEADAAEF};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'd0,  32'd0,        32'hDEADAAEF, 1'b0, 2, -1, 32'd0};
    vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'd6,  32'h0000BEEF, 32'd0,        1'b0, 3,  1, 32'hBEEF5678};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'd6,  32'd0,        32'hFFFFBEEF, 1'b0, 2, -1, 32'd0};
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'd8,  32'hCAFEF00D, 32'd0,        1'b0, 2,  2, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'd4,  32'd0,        32'h00005678, 1'b0, 2, -1, 32'd0};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'd0,  32'd0,        32'hFFFFFFEF, 1'b0, 2, -1, 32'd0};
`ifdef MEM_RMW_ALIGN_CHECK_EN
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'd2,  32'h12345678, 32'd0,        1'b1, 1,  0, 32'hDEADAAEF};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'd0,  32'd0,        32'hDEADAAEF, 1'b0, 2, -1, 32'd0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'd4,  32'd0,        32'd0,        1'b1, 1, -1, 32'd0};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 32'd7,  32'd0,        32'd0,        1'b1, 1, -1, 32'd0};
`else
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'd2,  32'h12345678, 32'd0,        1'b0, 2,  0, 32'h12345678};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'd0,  32'd0,        32'h12345678, 1'b0, 2, -1, 32'd0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'd4,  32'd0,        32'hBEEF5678, 1'b0, 2, -1, 32'd0};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 32'd7,  32'd0,        32'hFFFFBEEF, 1'b0, 2, -1, 32'd0};
`endif
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'd9,  32'd0,        32'hFFFFFFF0, 1'b0, 2, -1, 32'd0};
    vecs[14] = '{1'b0, 2'd1, 1'b1, 32'd10, 32'd0,        32'h0000CAFE, 1'b0, 2, -1, 32'd0};

    rst_n = 1'b0;
    pokeEn = 1'b0; pokeIdx = 4'd0; pokeVal = 32'd0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    #1;
    checkOutput("rstReqReady", bus.req_ready, 1'b1);
    checkOutput("rstRespValid", bus.resp_valid, 1'b0);
    checkOutput("rstRespErr", bus.resp_err, 1'b0);
    checkOutput("rstRespRdata", bus.resp_rdata, 32'd0);
    checkOutput("rstWriteEn", bus.mem_writeEn, 1'b0);
    checkOutput("rstMemAddress", bus.mem_address, 32'd0);
    checkOutput("rstWriteData", bus.mem_writeData, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    poke(0, 32'hDEADBEEF);
    poke(1, 32'h12345678);
    poke(2, 32'h00000000);

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].write, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    rdata, err, lat, weCnt, protoOk);
      checkOutput($sformatf("vec%0d.rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d.err", i), err, vecs[i].expErr);
      checkOutput($sformatf("vec%0d.latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d.writeEnCycles", i), weCnt,
                  (vecs[i].write && !vecs[i].expErr) ? 1 : 0);
      checkOutput($sformatf("vec%0d.protocol", i), protoOk, 1'b1);
      if (vecs[i].memIdx >= 0)
        checkOutput($sformatf("vec%0d.memWord", i), memWords[vecs[i].memIdx], vecs[i].expWord);
    end

    // Held req_valid: second load accepted right after the single IDLE cycle.
    $display("[TB] back-to-back loads");
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b1;
    bus.req_addr = 32'd8; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_size = 2'd0; bus.req_addr = 32'd9;
    r1Cycle = 0; r2Cycle = 0; r1Data = 32'd0; r2Data = 32'd0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) bus.req_valid = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        if (r1Cycle == 0) begin r1Cycle = c; r1Data = bus.resp_rdata; end
        else if (r2Cycle == 0) begin r2Cycle = c; r2Data = bus.resp_rdata; end
      end
      @(posedge clk); #1;
    end
    checkOutput("b2b.firstCycle", r1Cycle, 2);
    checkOutput("b2b.firstData", r1Data, 32'hCAFEF00D);
    checkOutput("b2b.secondCycle", r2Cycle, 5);
    checkOutput("b2b.secondData", r2Data, 32'h000000F0);

    $display("[TB] reset during RD and during WR");
    resetDuringStore(1);
    resetDuringStore(2);

    $display("[TB] random traffic against reference model");
    for (int wi = 0; wi < 16; wi++) begin
      val = $urandom;
      poke(wi, val);
      for (int b = 0; b < 4; b++) refBytes[4*wi+b] = val[8*b +: 8];
    end
    for (int t = 0; t < 150; t++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      val = $urandom;
      refModel(w, sz, u, a, val, expRdata, expErr, expLat);
      applyStimulus(w, sz, u, a, val, rdata, err, lat, weCnt, protoOk);
      checkOutput($sformatf("rnd%0d.rdata", t), rdata, expRdata);
      checkOutput($sformatf("rnd%0d.err", t), err, expErr);
      checkOutput($sformatf("rnd%0d.latency", t), lat, expLat);
      checkOutput($sformatf("rnd%0d.writeEnCycles", t), weCnt, (w && !expErr) ? 1 : 0);
      checkOutput($sformatf("rnd%0d.protocol", t), protoOk, 1'b1);
      checkOutput($sformatf("rnd%0d.memWord", t), memWords[a[5:2]], refWord(int'(a[5:2])));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
